// File: rtl/brick_fusion_seq.sv
// Serial bit-brick multiplier. It splits the N-bit operands (N = 2, 4 or 8) into
// 2-bit slices. Each RUN cycle multiplies one a-slice by one b-slice as a 2x2
// brick, and shift-accumulates the brick product into a 16-bit accumulator.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid / in_ready   operand handshake (a, b, sel, prec)
//   a, b                  8-bit operands, only the low N bits are used
//   sel                   00 signed, 01 unsigned, 10 a signed / b unsigned, 11 = 01
//   prec                  00 N=2, 01 N=4, 10 N=8, 11 = 10
//   out_valid / out_ready product handshake
//   p                     16-bit extended product, zero outside DONE
module brick_fusion_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [1:0]  sel,
  input  logic [1:0]  prec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] p
);

  localparam int unsigned OP_W  = 8;
  localparam int unsigned ACC_W = 16;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [OP_W-1:0]   a_q;
  logic [OP_W-1:0]   b_q;
  logic              a_signed;
  logic              b_signed;
  logic [1:0]        last_idx;   // index of the top slice: 0, 1 or 3
  logic [1:0]        i_cnt;      // a slice (inner loop)
  logic [1:0]        j_cnt;      // b slice (outer loop)
  logic [ACC_W-1:0]  acc;

  logic [1:0]        slice_a_c;
  logic [1:0]        slice_b_c;
  logic              top_a_c;
  logic              top_b_c;
  logic signed [2:0] ext_a_c;
  logic signed [2:0] ext_b_c;
  logic signed [5:0] prod_c;
  logic [3:0]        brick_c;
  logic [ACC_W-1:0]  partial_c;
  logic [3:0]        shamt_c;
  logic [ACC_W-1:0]  acc_next_c;
  logic              last_brick_c;

  // One brick. Only the top slice of a signed operand is signed. A brick is
  // signed when either slice is signed, so its product is sign-extended then.
  always_comb begin
    slice_a_c    = 2'(a_q >> {i_cnt, 1'b0});
    slice_b_c    = 2'(b_q >> {j_cnt, 1'b0});
    top_a_c      = a_signed && (i_cnt == last_idx);
    top_b_c      = b_signed && (j_cnt == last_idx);
    ext_a_c      = top_a_c ? {slice_a_c[1], slice_a_c} : {1'b0, slice_a_c};
    ext_b_c      = top_b_c ? {slice_b_c[1], slice_b_c} : {1'b0, slice_b_c};
    prod_c       = 6'(ext_a_c) * 6'(ext_b_c);
    brick_c      = prod_c[3:0];
    partial_c    = (top_a_c || top_b_c) ? {{12{brick_c[3]}}, brick_c}
                                        : {12'b0, brick_c};
    shamt_c      = {3'(i_cnt) + 3'(j_cnt), 1'b0};
    acc_next_c   = acc + (partial_c << shamt_c);
    last_brick_c = (i_cnt == last_idx) && (j_cnt == last_idx);
  end

  // Control FSM and datapath registers. All outputs are registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      a_signed  <= 1'b0;
      b_signed  <= 1'b0;
      last_idx  <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      acc       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      p         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q      <= a;
            b_q      <= b;
            a_signed <= (sel == 2'b00) || (sel == 2'b10);
            b_signed <= (sel == 2'b00);
            last_idx <= (prec == 2'b00) ? 2'd0 : (prec == 2'b01) ? 2'd1 : 2'd3;
            i_cnt    <= '0;
            j_cnt    <= '0;
            acc      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end
        RUN: begin
          acc <= acc_next_c;
          if (last_brick_c) begin
            state     <= DONE;
            out_valid <= 1'b1;
            p         <= acc_next_c;
          end else if (i_cnt == last_idx) begin
            i_cnt <= '0;
            j_cnt <= j_cnt + 2'd1;
          end else begin
            i_cnt <= i_cnt + 2'd1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            p         <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          p         <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_brick_fusion_seq.sv
// Self-checking bench for brick_fusion_seq. It checks directed cases and
// random operations against an arithmetic reference product.
module tb_brick_fusion_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  a;
  logic [7:0]  b;
  logic [1:0]  sel;
  logic [1:0]  prec;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] p;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  brick_fusion_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .sel       (sel),
    .prec      (prec),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p)
  );

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  function automatic int width_of(input logic [1:0] pr);
    return (pr == 2'b00) ? 2 : (pr == 2'b01) ? 4 : 8;
  endfunction

  // Reference: interpret the low N bits per sign mode, multiply, keep 16 bits.
  function automatic logic [15:0] ref_mul(input logic [7:0] ra, input logic [7:0] rb,
                                          input logic [1:0] rs, input logic [1:0] rp);
    int n, av, bv;
    n  = width_of(rp);
    av = int'(ra) & ((1 << n) - 1);
    bv = int'(rb) & ((1 << n) - 1);
    if ((rs == 2'b00 || rs == 2'b10) && av >= (1 << (n - 1))) av -= (1 << n);
    if (rs == 2'b00 && bv >= (1 << (n - 1))) bv -= (1 << n);
    return 16'(av * bv);
  endfunction

  // Issue one op, check latency and product, and hold DONE for `hold` cycles
  // while poking in_valid. Then release the product.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic [1:0] ts,
                        input logic [1:0] tp, input int hold, input string tag);
    logic [15:0] exp;
    int          k, lat;
    exp = ref_mul(ta, tb_v, ts, tp);
    k   = (width_of(tp) / 2) * (width_of(tp) / 2);
    check({tag, "_in_ready"}, 16'(in_ready), 16'd1);
    a = ta; b = tb_v; sel = ts; prec = tp; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = 8'($urandom); b = 8'($urandom); sel = 2'($urandom); prec = 2'($urandom);
    lat = 0;
    while (!out_valid && lat <= 40) begin
      check({tag, "_p_run"}, p, 16'd0);
      @(posedge clk); #1;
      lat++;
    end
    check({tag, "_latency"}, 16'(lat), 16'(k));
    check({tag, "_p"}, p, exp);
    for (int h = 0; h < hold; h++) begin
      in_valid = h[0];
      a = 8'($urandom);
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 16'(out_valid), 16'd1);
      check({tag, "_hold_ready"}, 16'(in_ready), 16'd0);
      check({tag, "_hold_p"}, p, exp);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check({tag, "_ret_ready"}, 16'(in_ready), 16'd1);
    check({tag, "_ret_valid"}, 16'(out_valid), 16'd0);
    check({tag, "_ret_p"}, p, 16'd0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; sel = '0; prec = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_in_ready", 16'(in_ready), 16'd1);
    check("reset_out_valid", 16'(out_valid), 16'd0);
    check("reset_p", p, 16'd0);
    rst = 1'b0;

    run_op(8'h80, 8'h80, 2'b00, 2'b10, 0, "s8_min");
    run_op(8'hFF, 8'hFF, 2'b01, 2'b10, 0, "u8_max");
    run_op(8'hFF, 8'hFF, 2'b10, 2'b10, 0, "su8_max");
    run_op(8'h02, 8'h03, 2'b00, 2'b00, 0, "s2");
    run_op(8'hFE, 8'hFF, 2'b00, 2'b00, 0, "s2_upper");
    run_op(8'h08, 8'h07, 2'b00, 2'b01, 0, "s4");
    run_op(8'hF8, 8'hF7, 2'b00, 2'b01, 0, "s4_upper");
    run_op(8'h5A, 8'hC3, 2'b10, 2'b01, 5, "hold5");

    // Abandon an 8-bit op with a reset on its 8th RUN cycle.
    a = 8'h80; b = 8'h80; sel = 2'b00; prec = 2'b10; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1; in_valid = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    check("abort_out_valid", 16'(out_valid), 16'd0);
    check("abort_in_ready", 16'(in_ready), 16'd1);
    check("abort_p", p, 16'd0);
    run_op(8'h03, 8'h05, 2'b01, 2'b10, 0, "after_abort");

    for (int r = 0; r < 60; r++) begin
      run_op(8'($urandom), 8'($urandom), 2'($urandom), 2'($urandom),
             int'($urandom_range(0, 3)), "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
